// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and memory-side signals of the cache bus arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = 2048
);
  logic [1:0]              req_valid;
  logic [1:0]              req_store;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*LINE_WIDTH-1:0] req_data;
  logic [1:0]              req_ready;
  logic [1:0]              resp_valid;
  logic [LINE_WIDTH-1:0]   resp_data;
  logic [1:0]              grant;
  logic                    mem_cmd_valid;
  logic                    mem_cmd_ready;
  logic                    mem_cmd_store;
  logic [ADDR_WIDTH-1:0]   mem_cmd_addr;
  logic [LINE_WIDTH-1:0]   mem_cmd_data;
  logic                    mem_resp_valid;
  logic [LINE_WIDTH-1:0]   mem_resp_data;

  modport slave (
    input  req_valid, req_store, req_addr, req_data,
    input  mem_cmd_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, grant,
    output mem_cmd_valid, mem_cmd_store, mem_cmd_addr, mem_cmd_data
  );

  modport master (
    output req_valid, req_store, req_addr, req_data,
    output mem_cmd_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, grant,
    input  mem_cmd_valid, mem_cmd_store, mem_cmd_addr, mem_cmd_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory bus between icache and dcache
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = 2048
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT_RESP} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic [1:0]            r_grant;
  logic                  r_cmd_valid;
  logic                  r_cmd_store;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [LINE_WIDTH-1:0] r_cmd_data;
  logic [1:0]            r_resp_valid;
  logic [LINE_WIDTH-1:0] r_resp_data;

  logic                  w_win;
  logic                  w_take;
  logic                  w_accept;
  logic                  w_resp;
  logic                  w_sel_store;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LINE_WIDTH-1:0] w_sel_data;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    w_win = bus.req_valid[1];
    if (bus.req_valid == 2'b11) begin
      w_win = ~r_last_grant;
    end
  end

  assign w_sel_store = bus.req_store[w_win];
  assign w_sel_addr  = w_win ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.req_addr[ADDR_WIDTH-1:0];
  assign w_sel_data  = w_win ? bus.req_data[2*LINE_WIDTH-1:LINE_WIDTH] : bus.req_data[LINE_WIDTH-1:0];

  assign w_take   = (r_state == IDLE) && (bus.req_valid != 2'b00);
  assign w_accept = (r_state == CMD) && bus.mem_cmd_ready;
  assign w_resp   = (r_state == WAIT_RESP) && bus.mem_resp_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    bus.req_ready = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_next_state = CMD;
        end
      end
      CMD: begin
        if (bus.mem_cmd_ready) begin
          bus.req_ready = r_grant;
          w_next_state  = r_cmd_store ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (bus.mem_resp_valid) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Command is captured at grant, so requester changes afterwards are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_grant      <= 2'b00;
      r_cmd_valid  <= 1'b0;
      r_cmd_store  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_data   <= '0;
      r_resp_valid <= 2'b00;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 2'b00;
      if (w_take) begin
        r_grant      <= w_win ? 2'b10 : 2'b01;
        r_last_grant <= w_win;
        r_cmd_valid  <= 1'b1;
        r_cmd_store  <= w_sel_store;
        r_cmd_addr   <= w_sel_addr;
        r_cmd_data   <= w_sel_data;
      end
      if (w_accept) begin
        r_cmd_valid <= 1'b0;
        if (r_cmd_store) begin
          r_grant <= 2'b00;
        end
      end
      if (w_resp) begin
        r_resp_data  <= bus.mem_resp_data;
        r_resp_valid <= r_grant;
        r_grant      <= 2'b00;
      end
    end
  end

  assign bus.grant         = r_grant;
  assign bus.mem_cmd_valid = r_cmd_valid;
  assign bus.mem_cmd_store = r_cmd_store;
  assign bus.mem_cmd_addr  = r_cmd_addr;
  assign bus.mem_cmd_data  = r_cmd_data;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_resp_data;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - vector table, corner sequences and randomized model check of mem_bus_arbiter
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int AW = 64;
  localparam int LW = 2048;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
  mem_bus_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got low64 %016h high64 %016h expected low64 %016h high64 %016h",
               name, act[63:0], act[LW-1:LW-64], exp[63:0], exp[LW-1:LW-64]);
    end
  endtask

  function automatic logic [LW-1:0] rep16(input logic [15:0] v);
    return {(LW/16){v}};
  endfunction

  function automatic logic [LW-1:0] rep8(input logic [7:0] v);
    return {(LW/8){v}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [1:0] oh(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  typedef struct {
    logic [1:0]  rv, rs;
    logic [15:0] a0, a1;
    logic        mrdy, mrv;
    logic [7:0]  mb;
    logic [1:0]  g;
    logic        cv, cs;
    logic [15:0] ca;
    logic [1:0]  rdy, rsp;
    logic [7:0]  rb;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [1:0] rv, input logic [1:0] rs, input logic [15:0] a0, input logic [15:0] a1,
                     input logic mrdy, input logic mrv, input logic [7:0] mb,
                     input logic [1:0] g, input logic cv, input logic cs, input logic [15:0] ca,
                     input logic [1:0] rdy, input logic [1:0] rsp, input logic [7:0] rb);
    vec_t v;
    v.rv = rv; v.rs = rs; v.a0 = a0; v.a1 = a1; v.mrdy = mrdy; v.mrv = mrv; v.mb = mb;
    v.g = g; v.cv = cv; v.cs = cs; v.ca = ca; v.rdy = rdy; v.rsp = rsp; v.rb = rb;
    vt.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.req_valid      = 2'b00;
    bus.req_store      = 2'b00;
    bus.req_addr       = '0;
    bus.req_data       = '0;
    bus.mem_cmd_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " grant"}, bus.grant, 2'b00);
    chk({tag, " cmd_valid"}, bus.mem_cmd_valid, 1'b0);
    chk({tag, " cmd_store"}, bus.mem_cmd_store, 1'b0);
    chk({tag, " cmd_addr"}, bus.mem_cmd_addr, 64'h0);
    chk_line({tag, " cmd_data"}, bus.mem_cmd_data, '0);
    chk({tag, " resp_valid"}, bus.resp_valid, 2'b00);
    chk_line({tag, " resp_data"}, bus.resp_data, '0);
    chk({tag, " req_ready"}, bus.req_ready, 2'b00);
  endtask

  // Transaction-level reference: requester/memory agents plus the arbitration rules.
  bit              pend[2];
  bit              cool[2];
  logic            r_st[2];
  logic [AW-1:0]   r_ad[2];
  logic [LW-1:0]   r_dt[2];
  bit              busy, acc;
  int              owner, last_win, lat, exp_rsp_port;
  logic            m_store;
  logic [AW-1:0]   m_addr;
  logic [LW-1:0]   m_data, exp_rdata, hold_rdata;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    do_reset();

    // Main vector table: one row per cycle, outputs checked just after inputs apply.
    add(2'b01, 2'b00, 16'h1000, 16'h0000, 0, 0, 8'h00, 2'b00, 0, 0, 16'h0000, 2'b00, 2'b00, 8'h00);
    add(2'b01, 2'b00, 16'h1000, 16'h0000, 1, 0, 8'h00, 2'b01, 1, 0, 16'h1000, 2'b01, 2'b00, 8'h00);
    add(2'b00, 2'b00, 16'h1000, 16'h0000, 0, 0, 8'h00, 2'b01, 0, 0, 16'h1000, 2'b00, 2'b00, 8'h00);
    add(2'b00, 2'b00, 16'h1000, 16'h0000, 0, 0, 8'h00, 2'b01, 0, 0, 16'h1000, 2'b00, 2'b00, 8'h00);
    add(2'b00, 2'b00, 16'h1000, 16'h0000, 0, 1, 8'hA5, 2'b01, 0, 0, 16'h1000, 2'b00, 2'b00, 8'h00);
    add(2'b00, 2'b00, 16'h1000, 16'h0000, 0, 0, 8'h00, 2'b00, 0, 0, 16'h1000, 2'b00, 2'b01, 8'hA5);
    add(2'b10, 2'b10, 16'h1000, 16'h2040, 0, 0, 8'h00, 2'b00, 0, 0, 16'h1000, 2'b00, 2'b00, 8'hA5);
    for (int k = 0; k < 4; k++)
      add(2'b10, 2'b10, 16'h1000, 16'h2040, 0, 0, 8'h00, 2'b10, 1, 1, 16'h2040, 2'b00, 2'b00, 8'hA5);
    add(2'b10, 2'b10, 16'h1000, 16'h2040, 1, 0, 8'h00, 2'b10, 1, 1, 16'h2040, 2'b10, 2'b00, 8'hA5);
    add(2'b00, 2'b00, 16'h1000, 16'h2040, 0, 0, 8'h00, 2'b00, 0, 1, 16'h2040, 2'b00, 2'b00, 8'hA5);
    add(2'b11, 2'b11, 16'h3000, 16'h4000, 1, 0, 8'h00, 2'b00, 0, 1, 16'h2040, 2'b00, 2'b00, 8'hA5);
    add(2'b11, 2'b11, 16'h3000, 16'h4000, 1, 0, 8'h00, 2'b01, 1, 1, 16'h3000, 2'b01, 2'b00, 8'hA5);
    add(2'b10, 2'b11, 16'h3000, 16'h4000, 1, 0, 8'h00, 2'b00, 0, 1, 16'h3000, 2'b00, 2'b00, 8'hA5);
    add(2'b11, 2'b11, 16'h3000, 16'h4000, 1, 0, 8'h00, 2'b10, 1, 1, 16'h4000, 2'b10, 2'b00, 8'hA5);
    add(2'b01, 2'b11, 16'h3000, 16'h4000, 1, 0, 8'h00, 2'b00, 0, 1, 16'h4000, 2'b00, 2'b00, 8'hA5);
    add(2'b11, 2'b11, 16'h3000, 16'h4000, 1, 0, 8'h00, 2'b01, 1, 1, 16'h3000, 2'b01, 2'b00, 8'hA5);
    add(2'b10, 2'b11, 16'h3000, 16'h4000, 1, 0, 8'h00, 2'b00, 0, 1, 16'h3000, 2'b00, 2'b00, 8'hA5);
    add(2'b00, 2'b11, 16'h3000, 16'h4000, 1, 0, 8'h00, 2'b10, 1, 1, 16'h4000, 2'b10, 2'b00, 8'hA5);
    add(2'b00, 2'b00, 16'h3000, 16'h4000, 0, 0, 8'h00, 2'b00, 0, 1, 16'h4000, 2'b00, 2'b00, 8'hA5);
    add(2'b01, 2'b00, 16'h5000, 16'h4000, 0, 1, 8'h5A, 2'b00, 0, 1, 16'h4000, 2'b00, 2'b00, 8'hA5);
    add(2'b01, 2'b00, 16'h5000, 16'h4000, 0, 1, 8'h5A, 2'b01, 1, 0, 16'h5000, 2'b00, 2'b00, 8'hA5);
    add(2'b01, 2'b00, 16'h5000, 16'h4000, 1, 0, 8'h00, 2'b01, 1, 0, 16'h5000, 2'b01, 2'b00, 8'hA5);
    add(2'b00, 2'b00, 16'h5000, 16'h4000, 0, 0, 8'h00, 2'b01, 0, 0, 16'h5000, 2'b00, 2'b00, 8'hA5);
    add(2'b00, 2'b00, 16'h5000, 16'h4000, 0, 1, 8'h3C, 2'b01, 0, 0, 16'h5000, 2'b00, 2'b00, 8'hA5);
    add(2'b01, 2'b00, 16'h6000, 16'h4000, 0, 0, 8'h00, 2'b00, 0, 0, 16'h5000, 2'b00, 2'b01, 8'h3C);
    add(2'b01, 2'b00, 16'h6000, 16'h4000, 1, 0, 8'h00, 2'b01, 1, 0, 16'h6000, 2'b01, 2'b00, 8'h3C);
    add(2'b00, 2'b00, 16'h6000, 16'h4000, 0, 1, 8'h77, 2'b01, 0, 0, 16'h6000, 2'b00, 2'b00, 8'h3C);
    add(2'b00, 2'b00, 16'h6000, 16'h4000, 0, 0, 8'h00, 2'b00, 0, 0, 16'h6000, 2'b00, 2'b01, 8'h77);
    add(2'b00, 2'b00, 16'h6000, 16'h4000, 0, 0, 8'h00, 2'b00, 0, 0, 16'h6000, 2'b00, 2'b00, 8'h77);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      bus.req_valid      = vt[i].rv;
      bus.req_store      = vt[i].rs;
      bus.req_addr       = {48'h0, vt[i].a1, 48'h0, vt[i].a0};
      bus.req_data       = {rep16(vt[i].a1), rep16(vt[i].a0)};
      bus.mem_cmd_ready  = vt[i].mrdy;
      bus.mem_resp_valid = vt[i].mrv;
      bus.mem_resp_data  = rep8(vt[i].mb);
      #1;
      chk($sformatf("row%0d grant", i), bus.grant, vt[i].g);
      chk($sformatf("row%0d cmd_valid", i), bus.mem_cmd_valid, vt[i].cv);
      chk($sformatf("row%0d cmd_store", i), bus.mem_cmd_store, vt[i].cs);
      chk($sformatf("row%0d cmd_addr", i), bus.mem_cmd_addr, {48'h0, vt[i].ca});
      chk($sformatf("row%0d req_ready", i), bus.req_ready, vt[i].rdy);
      chk($sformatf("row%0d resp_valid", i), bus.resp_valid, vt[i].rsp);
      chk_line($sformatf("row%0d resp_data", i), bus.resp_data, rep8(vt[i].rb));
      if (vt[i].cv) chk_line($sformatf("row%0d cmd_data", i), bus.mem_cmd_data, rep16(vt[i].ca));
    end

    // Reset during WAIT_RESP of a port 0 load, then a late memory response.
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_store = 2'b00; bus.req_addr = {64'h0, 64'h7000};
    @(negedge clk);
    bus.mem_cmd_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 2'b00; bus.mem_cmd_ready = 1'b0;
    #1;
    chk("midrst before grant", bus.grant, 2'b01);
    #1;
    bus.mem_cmd_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    reset = 1'b1; bus.mem_cmd_ready = 1'b0;
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = rep8(8'hEE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      #1;
      chk($sformatf("late resp_valid %0d", k), bus.resp_valid, 2'b00);
      chk_line($sformatf("late resp_data %0d", k), bus.resp_data, '0);
      chk($sformatf("late grant %0d", k), bus.grant, 2'b00);
    end

    // After reset a tie goes to port 0 first, then alternates.
    @(negedge clk);
    bus.req_valid = 2'b11; bus.req_store = 2'b11; bus.mem_cmd_ready = 1'b1;
    bus.req_addr = {64'hB000, 64'hA000};
    bus.req_data = {rep16(16'h0000), {(LW-32)'(0), 32'h0000_1234}};
    @(negedge clk);
    #1;
    chk("tie grant0", bus.grant, 2'b01);
    chk_line("tie store data", bus.mem_cmd_data, {(LW-32)'(0), 32'h0000_1234});
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = 2'b11;
    @(negedge clk);
    #1;
    chk("tie grant1", bus.grant, 2'b10);
    chk("tie addr1", bus.mem_cmd_addr, 64'hB000);

    // Randomized run against the transaction-level model.
    do_reset();
    for (int p = 0; p < 2; p++) begin pend[p] = 0; cool[p] = 0; end
    busy = 0; acc = 0; owner = 0; last_win = 1; lat = 0; exp_rsp_port = -1;
    hold_rdata = '0; exp_rdata = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [LW-1:0] mdata;
      logic          mrv, mrdy;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (cool[p]) cool[p] = 0;
        else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          r_st[p] = 1'($urandom_range(0, 1));
          r_ad[p] = {$urandom, $urandom};
          r_dt[p] = rand_line();
        end
      end
      mdata = rand_line();
      if (busy && acc && !m_store) begin
        mrv = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        mrv = ($urandom_range(0, 9) == 0);
      end
      mrdy = 1'($urandom_range(0, 1));
      bus.req_valid      = {pend[1] ? 1'b1 : 1'b0, pend[0] ? 1'b1 : 1'b0};
      bus.req_store      = {r_st[1], r_st[0]};
      bus.req_addr       = {r_ad[1], r_ad[0]};
      bus.req_data       = {r_dt[1], r_dt[0]};
      bus.mem_cmd_ready  = mrdy;
      bus.mem_resp_valid = mrv;
      bus.mem_resp_data  = mdata;
      #1;
      chk("rnd resp_valid", bus.resp_valid, (exp_rsp_port >= 0) ? oh(exp_rsp_port) : 2'b00);
      if (exp_rsp_port >= 0) hold_rdata = exp_rdata;
      chk_line("rnd resp_data", bus.resp_data, hold_rdata);
      exp_rsp_port = -1;
      if (!busy) begin
        chk("rnd idle grant", bus.grant, 2'b00);
        chk("rnd idle cmd_valid", bus.mem_cmd_valid, 1'b0);
        chk("rnd idle req_ready", bus.req_ready, 2'b00);
        if (pend[0] || pend[1]) begin
          owner    = (pend[0] && pend[1]) ? 1 - last_win : (pend[1] ? 1 : 0);
          last_win = owner;
          busy = 1; acc = 0;
          m_store = r_st[owner]; m_addr = r_ad[owner]; m_data = r_dt[owner];
        end
      end else if (!acc) begin
        chk("rnd cmd grant", bus.grant, oh(owner));
        chk("rnd cmd_valid", bus.mem_cmd_valid, 1'b1);
        chk("rnd cmd_store", bus.mem_cmd_store, m_store);
        chk("rnd cmd_addr", bus.mem_cmd_addr, m_addr);
        chk_line("rnd cmd_data", bus.mem_cmd_data, m_data);
        chk("rnd cmd req_ready", bus.req_ready, mrdy ? oh(owner) : 2'b00);
        if (mrdy) begin
          acc = 1; pend[owner] = 0; cool[owner] = 1;
          if (m_store) busy = 0;
          else lat = $urandom_range(0, 4);
        end
      end else begin
        chk("rnd wait grant", bus.grant, oh(owner));
        chk("rnd wait cmd_valid", bus.mem_cmd_valid, 1'b0);
        chk("rnd wait req_ready", bus.req_ready, 2'b00);
        if (mrv) begin
          exp_rsp_port = owner; exp_rdata = mdata; busy = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory bus between the instruction-side and data-side direct-mapped caches. It accepts whole-line load and store commands from two requesters and arbitrates round-robin. It runs one transaction at a time against memory and returns load lines to the requester that issued them. It sits between the two cache bus ports and the memory controller.

## Interface
- ADDR_WIDTH, 64, byte address width
- LINE_WIDTH, 2048, cache line width (DATA_WIDTH * 2**OFFSET_LENGTH)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; one clock (clk)
- req_valid  in  2  command_valid per requester; bit 0 = icache, bit 1 = dcache
- req_store  in  2  1 = store line, 0 = load line
- req_addr  in  2*ADDR_WIDTH  port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  2*LINE_WIDTH  store line, port i at [i*LINE_WIDTH +: LINE_WIDTH]
- req_ready  out  2  one-cycle pulse: command accepted by memory (requester bus_ready)
- resp_valid  out  2  one-cycle pulse: load line on resp_data (requester bus_valid)
- resp_data  out  LINE_WIDTH  returned load line, shared by both ports
- grant  out  2  one-hot owner of current transaction, 0 when idle
- mem_cmd_valid  out  1  command to memory
- mem_cmd_ready  in  1  memory accepts command this cycle
- mem_cmd_store  out  1  command type
- mem_cmd_addr  out  ADDR_WIDTH  command address
- mem_cmd_data  out  LINE_WIDTH  store line
- mem_resp_valid  in  1  load response valid
- mem_resp_data  in  LINE_WIDTH  load response line

## Operation
- States: IDLE, CMD, WAIT_RESP.
- IDLE:
  - If any req_valid bit is set, pick a winner and go to CMD.
  - On the same edge, latch the winner's store/addr/data into the mem_cmd_* registers, set grant, and set mem_cmd_valid.
- Arbitration:
  - Only one requesting port: that port wins.
  - Both requesting: the port not recorded in last_grant wins.
  - last_grant updates to the winner on every grant.
- CMD:
  - mem_cmd_valid is held high until mem_cmd_ready.
  - req_ready[winner] = (state==CMD) & mem_cmd_ready, combinational.
  - On accept, clear mem_cmd_valid.
  - Next state on accept: store goes to IDLE with grant cleared; load goes to WAIT_RESP.
- WAIT_RESP:
  - On mem_resp_valid, register mem_resp_data into resp_data and pulse resp_valid[winner] the next cycle.
  - On the same edge go to IDLE and clear grant.
- mem_resp_valid in IDLE or CMD is ignored. It causes no resp_valid and leaves resp_data unchanged.
- req_valid changes while not in IDLE are ignored, because the command was captured at grant.
- Requester rule: deassert req_valid in the cycle after req_ready. A req_valid high while in IDLE is a new request.
- req_data of a load is don't-care. mem_cmd_data is still latched.

## Timing
- Reset (asynchronous, reset=0) forces:
  - state=IDLE, last_grant=port 1, so port 0 wins the first tie.
  - grant=0, mem_cmd_valid=0, mem_cmd_store=0, mem_cmd_addr=0, mem_cmd_data=0.
  - resp_valid=0, resp_data=0; req_ready=0, because it is derived from state.
- Reset mid-transaction: the transaction is abandoned. A late mem_resp_valid after reset is ignored.
- Request at cycle t in IDLE gives mem_cmd_valid=1 at t+1.
- Store with a zero-wait memory: accepted at t+1, IDLE at t+2. Minimum 2 cycles per store.
- Load: accept at t+1, WAIT_RESP from t+2. mem_resp_valid at cycle r gives resp_valid at r+1, with state IDLE at r+1.
- A new grant may be taken in the cycle resp_valid is high.
- Backpressure: each cycle mem_cmd_ready=0 in CMD adds one cycle, with mem_cmd_* stable.
- Round-robin guarantee: with both ports continuously requesting, grants strictly alternate 0,1,0,1.

## Test plan
- Load, port 0 only:
  - Stimulus: req_valid=01, addr 0x1000; memory accepts at once and returns the line 3 cycles later with pattern 0xA5...A5.
  - Required: mem_cmd_valid at t+1 with mem_cmd_addr=0x1000, mem_cmd_store=0; req_ready=01 at t+1; resp_valid=01 one cycle after mem_resp_valid, resp_data=0xA5...A5; grant returns to 00.
- Store, port 1 with backpressure:
  - Stimulus: req_valid=10, req_store=10, addr 0x2040, data 0x1234 in the low word; mem_cmd_ready low for 4 cycles.
  - Required: mem_cmd_* stable for 5 cycles; req_ready=10 only in the accept cycle; no resp_valid.
- Simultaneous requests after reset: req_valid=11 on consecutive stores.
  - Required: grant sequence 01,10,01,10.
- Reset mid-transaction:
  - Stimulus: assert reset during WAIT_RESP of a port 0 load, release, then fire mem_resp_valid.
  - Required: all outputs are 0 immediately on reset; no resp_valid after release.
- Spurious response:
  - Stimulus: mem_resp_valid=1 in IDLE, then again in CMD.
  - Required: resp_valid stays 00 and resp_data is unchanged.
- Back-to-back loads, port 0:
  - Stimulus: new req_valid in the cycle resp_valid=01 is high.
  - Required: mem_cmd_valid rises the next cycle with the new address.
